// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the operand-alignment stage:
// field widths, special encodings, operand classification and the
// register payload types passed between the two pipeline stages.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    // Hidden bit + fraction + guard/round/sticky.
    localparam int ALIGN_W = MAN_W + 4;

    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF  = 32'hFF80_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] NEG_ZERO = 32'h8000_0000;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

    // One unpacked operand; sign is already the effective sign.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   mant;   // hidden bit in the MSB
        fp_class_e        cls;
    } fp_operand_t;

    // Everything the downstream ALU sees for one aligned pair.
    typedef struct packed {
        logic               sign_big;
        logic               sign_small;
        logic [EXP_W-1:0]   exp_big;
        logic [MAN_W:0]     mant_big;
        logic [ALIGN_W-1:0] mant_small;
        logic               eff_sub;
        logic               special_valid;
        logic [31:0]        special_result;
    } align_out_t;

    // Split and classify a raw IEEE-754 word. Zero operands carry a zero
    // mantissa and exponent so they always lose the magnitude compare.
    function automatic fp_operand_t fp_unpack(input logic [31:0] word,
                                              input logic        flip_sign,
                                              input logic        flush_denorm);
        fp_operand_t      op;
        logic [EXP_W-1:0] exp_f;
        logic [MAN_W-1:0] frac_f;
        exp_f   = word[30:23];
        frac_f  = word[22:0];
        op.sign = word[31] ^ flip_sign;
        op.exp  = exp_f;
        op.mant = {(exp_f != '0), frac_f};
        if (exp_f == '1) begin
            op.cls = (frac_f == '0) ? INF : NAN;
        end else if ((exp_f == '0) && (flush_denorm || (frac_f == '0))) begin
            op.cls  = ZERO;
            op.mant = '0;
        end else begin
            op.cls = NORMAL;
        end
        return op;
    endfunction

endpackage

// File: rtl/fp_operand_align_if.sv
// Upstream operand channel and downstream aligned-result channel of the
// alignment stage, bundled so the loader, the stage and the ALU share one
// definition.
interface fp_operand_align_if;
    import fp_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [31:0]         A;
    logic [31:0]         B;
    logic                op_sub;

    logic                out_valid;
    logic                out_ready;
    logic                sign_big;
    logic                sign_small;
    logic [EXP_W-1:0]    exp_big;
    logic [MAN_W:0]      mant_big;
    logic [ALIGN_W-1:0]  mant_small;
    logic                eff_sub;
    logic                special_valid;
    logic [31:0]         special_result;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, A, B, op_sub, out_ready,
        input  in_ready, out_valid, sign_big, sign_small, exp_big,
               mant_big, mant_small, eff_sub, special_valid, special_result
    );

    // The alignment stage itself.
    modport slave (
        input  in_valid, A, B, op_sub, out_ready,
        output in_ready, out_valid, sign_big, sign_small, exp_big,
               mant_big, mant_small, eff_sub, special_valid, special_result
    );

endinterface

// File: rtl/fp_align_shifter.sv
// Right barrel shift of the smaller mantissa with a sticky bit: every bit
// pushed out of the word is ORed into bit 0. Purely combinational.
module fp_align_shifter
    import fp_pkg::*;
(
    input  logic [ALIGN_W-1:0] mant_i,
    input  logic [EXP_W-1:0]   shamt_i,
    output logic [ALIGN_W-1:0] mant_o
);

    logic [ALIGN_W-1:0] shifted;
    logic [ALIGN_W-1:0] lost_mask;

    // Shift, then fold the discarded bits into the sticky position.
    // NOTE: every variable gets a value on every path through an always_comb, otherwise a latch is inferred.
    always_comb begin
        shifted   = mant_i >> shamt_i;
        lost_mask = '1;
        if (shamt_i < EXP_W'(ALIGN_W)) begin
            lost_mask = ~({ALIGN_W{1'b1}} << shamt_i[4:0]);
        end
        mant_o = {shifted[ALIGN_W-1:1], shifted[0] | (|(mant_i & lost_mask))};
    end

endmodule

// File: rtl/fp_operand_align.sv
// Two-stage operand aligner in front of the FP adder: S1 unpacks and
// classifies A and B, S2 orders them by magnitude, aligns the smaller
// mantissa and resolves NaN/inf/zero results that need no arithmetic.
module fp_operand_align
    import fp_pkg::*;
#(
    parameter bit FLUSH_DENORM = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    fp_operand_align_if.slave  bus
);

    logic        s2_free;
    logic        in_ready;

    logic        s1_valid_q, s1_valid_d;
    fp_operand_t s1_a_q, s1_a_d;
    fp_operand_t s1_b_q, s1_b_d;

    logic        out_valid_q, out_valid_d;
    align_out_t  out_q, out_d;

    fp_operand_t        op_big;
    fp_operand_t        op_small;
    logic               a_is_big;
    logic [EXP_W-1:0]   exp_diff;
    logic [ALIGN_W-1:0] small_aligned;
    align_out_t         s2_res;

    // S2 can take a new pair when it is empty or being drained this cycle;
    // S1 can take one when it is empty or moving into S2.
    assign s2_free  = !out_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s2_free;

    // S1 next state: capture and classify a new pair on transfer.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_a_d = fp_unpack(bus.A, 1'b0, FLUSH_DENORM);
                s1_b_d = fp_unpack(bus.B, bus.op_sub, FLUSH_DENORM);
            end
        end
    end

    // Order operands by magnitude; a tie keeps A as the big operand.
    always_comb begin
        a_is_big = {s1_a_q.exp, s1_a_q.mant} >= {s1_b_q.exp, s1_b_q.mant};
        op_big   = a_is_big ? s1_a_q : s1_b_q;
        op_small = a_is_big ? s1_b_q : s1_a_q;
        exp_diff = op_big.exp - op_small.exp;
    end

    fp_align_shifter u_shifter (
        .mant_i  ({op_small.mant, 3'b000}),
        .shamt_i (exp_diff),
        .mant_o  (small_aligned)
    );

    // Assemble the aligned pair and resolve special operand combinations
    // in priority order: NaN, inf-inf, inf, zero+zero.
    always_comb begin
        s2_res                = '0;
        s2_res.sign_big       = op_big.sign;
        s2_res.sign_small     = op_small.sign;
        s2_res.exp_big        = op_big.exp;
        s2_res.mant_big       = op_big.mant;
        s2_res.mant_small     = small_aligned;
        s2_res.eff_sub        = op_big.sign ^ op_small.sign;
        s2_res.special_valid  = 1'b1;
        if ((s1_a_q.cls == NAN) || (s1_b_q.cls == NAN)) begin
            s2_res.special_result = QNAN;
        end else if ((s1_a_q.cls == INF) && (s1_b_q.cls == INF) &&
                     (s1_a_q.sign != s1_b_q.sign)) begin
            s2_res.special_result = QNAN;
        end else if (s1_a_q.cls == INF) begin
            s2_res.special_result = s1_a_q.sign ? NEG_INF : POS_INF;
        end else if (s1_b_q.cls == INF) begin
            s2_res.special_result = s1_b_q.sign ? NEG_INF : POS_INF;
        end else if ((s1_a_q.cls == ZERO) && (s1_b_q.cls == ZERO)) begin
            s2_res.special_result = (s1_a_q.sign && s1_b_q.sign) ? NEG_ZERO : POS_ZERO;
        end else begin
            s2_res.special_valid  = 1'b0;
            s2_res.special_result = '0;
        end
    end

    // S2 next state: load from S1 when free, otherwise hold outputs stable.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (s2_free) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d = s2_res;
            end
        end
    end

    // Pipeline registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            // NOTE: data registers are cleared too, so nothing stale is visible after reset.
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            out_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            out_q       <= out_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.sign_big       = out_q.sign_big;
    assign bus.sign_small     = out_q.sign_small;
    assign bus.exp_big        = out_q.exp_big;
    assign bus.mant_big       = out_q.mant_big;
    assign bus.mant_small     = out_q.mant_small;
    assign bus.eff_sub        = out_q.eff_sub;
    assign bus.special_valid  = out_q.special_valid;
    assign bus.special_result = out_q.special_result;

endmodule
